// File: rtl/data_mem_responder_pkg.sv
// Shared core/data-memory handshake types and the responder's state encoding.
package data_mem_responder_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    IDLE_M,
    WAIT_M,
    RESP_M
  } dmem_state_e;

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-organised RAM: byte-enabled synchronous write, asynchronous read.
module data_mem_array #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic [3:0]              byte_en,
  input  logic [addr_width_p-1:0] addr,
  input  logic [31:0]             write_data,
  output logic [31:0]             read_data
);

  logic [31:0] mem [2**addr_width_p];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) mem[addr][i*8 +: 8] <= write_data[i*8 +: 8];
    end
  end

  assign read_data = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory endpoint: accepts one load/store at a time over valid/yumi and
// answers after latency_p extra cycles, holding the response until the core takes it.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o
);

  localparam int cnt_w = (latency_p > 0) ? $clog2(latency_p + 1) : 1;
  localparam logic [cnt_w-1:0] cnt_init = cnt_w'((latency_p > 0) ? latency_p - 1 : 0);

  dmem_state_e             state_reg;
  logic [cnt_w-1:0]        cnt_reg;
  logic                    valid_reg;
  logic [31:0]             read_data_reg;

  logic                    accept;
  logic [addr_width_p-1:0] word_idx;
  logic [1:0]              lane;
  logic [3:0]              byte_en;
  logic [3:0]              ram_we;
  logic [31:0]             wdata_rep;
  logic [31:0]             ram_word;
  logic [31:0]             merged;
  logic [7:0]              lane_byte;
  logic [31:0]             resp_data;
  logic                    unused_addr_bits;

  assign accept   = (state_reg == IDLE_M) && to_mem_i.valid;
  assign word_idx = addr_i[addr_width_p+1:2];
  assign lane     = addr_i[1:0];
  assign unused_addr_bits = ^addr_i[31:addr_width_p+2];

  // Byte stores replicate the low byte so any lane can pick it up.
  assign wdata_rep = to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}}
                                            : to_mem_i.write_data;
  assign byte_en   = to_mem_i.byte_not_word ? (4'b0001 << lane) : 4'hF;
  assign ram_we    = (accept && to_mem_i.wen) ? byte_en : 4'h0;

  data_mem_array #(.addr_width_p(addr_width_p)) u_array (
    .clk        (clk),
    .byte_en    (ram_we),
    .addr       (word_idx),
    .write_data (wdata_rep),
    .read_data  (ram_word)
  );

  // Post-write word for store responses, built from the pre-write read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8] : ram_word[gi*8 +: 8];
  end

  always_comb begin
    lane_byte = ram_word[7:0];
    case (lane)
      2'd1:    lane_byte = ram_word[15:8];
      2'd2:    lane_byte = ram_word[23:16];
      2'd3:    lane_byte = ram_word[31:24];
      default: lane_byte = ram_word[7:0];
    endcase
  end

  always_comb begin
    resp_data = ram_word;
    if (to_mem_i.wen)                resp_data = merged;
    else if (to_mem_i.byte_not_word) resp_data = {24'h0, lane_byte};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE_M;
      cnt_reg       <= '0;
      valid_reg     <= 1'b0;
      read_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE_M: begin
          if (accept) begin
            read_data_reg <= resp_data;
            if (latency_p > 0) begin
              state_reg <= WAIT_M;
              cnt_reg   <= cnt_init;
            end else begin
              state_reg <= RESP_M;
              valid_reg <= 1'b1;
            end
          end
        end
        WAIT_M: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP_M;
            valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - cnt_w'(1);
          end
        end
        RESP_M: begin
          if (to_mem_i.yumi) begin
            state_reg <= IDLE_M;
            valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE_M;
      endcase
    end
  end

  always_comb begin
    from_mem_o.read_data = read_data_reg;
    from_mem_o.valid     = valid_reg;
    from_mem_o.yumi      = accept;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a latency-2 and a latency-0 responder driven by directed requests.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  mem_in_s     req [2];
  logic [31:0] addr [2];
  mem_out_s    rsp [2];
  int          lat [2] = '{2, 0};

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  always #5 clk = ~clk;

  data_mem_responder #(.addr_width_p(10), .latency_p(2)) dut (
    .clk(clk), .reset(reset), .to_mem_i(req[0]), .addr_i(addr[0]), .from_mem_o(rsp[0]));

  data_mem_responder #(.addr_width_p(10), .latency_p(0)) dut0 (
    .clk(clk), .reset(reset), .to_mem_i(req[1]), .addr_i(addr[1]), .from_mem_o(rsp[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: a response is consumed whenever valid meets the core's yumi.
  always @(negedge clk) begin
    if (!reset && rsp[0].valid && req[0].yumi) begin
      if (exp_q0.size() == 0) check("dut_unexpected_resp", rsp[0].read_data, 32'hxxxxxxxx);
      else check("dut_resp_data", rsp[0].read_data, exp_q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && rsp[1].valid && req[1].yumi) begin
      if (exp_q1.size() == 0) check("dut0_unexpected_resp", rsp[1].read_data, 32'hxxxxxxxx);
      else check("dut0_resp_data", rsp[1].read_data, exp_q1.pop_front());
    end
  end

  task automatic request(input int w, input logic wen, input logic bnw,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp, input int hold);
    int n;
    @(posedge clk); #1;
    req[w].valid = 1'b1; req[w].wen = wen; req[w].byte_not_word = bnw;
    req[w].write_data = wd; addr[w] = a;
    if (w == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
    $display("txn dut%0d %s %s addr=%h wdata=%h expect=%h", w, wen ? "store" : "load",
             bnw ? "byte" : "word", a, wd, exp);
    @(negedge clk);
    check("accept_yumi", 32'(rsp[w].yumi), 32'd1);
    @(posedge clk); #1;
    req[w].valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rsp[w].valid && n < 20) begin
      check("wait_yumi_low", 32'(rsp[w].yumi), 32'd0);
      n++;
      @(negedge clk);
    end
    check("valid_latency", 32'(n), 32'(lat[w] + 1));
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(rsp[w].valid), 32'd1);
      check("hold_data", rsp[w].read_data, exp);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req[w].yumi = 1'b1;
    @(negedge clk);
    check("no_yumi_in_resp", 32'(rsp[w].yumi), 32'd0);
    @(posedge clk); #1;
    req[w].yumi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int yumis;
    int valids;
    for (int w = 0; w < 2; w++) begin
      req[w] = '0;
      addr[w] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        check("reset_valid", 32'(rsp[w].valid), 32'd0);
        check("reset_yumi", 32'(rsp[w].yumi), 32'd0);
        check("reset_data", rsp[w].read_data, 32'd0);
      end
    end

    request(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 2);
    request(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
    request(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 32'h11223344, 1);
    request(0, 1'b1, 1'b1, 32'h22, 32'h000000AA, 32'h11AA3344, 1);
    request(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 1);
    request(0, 1'b0, 1'b1, 32'h23, 32'h0, 32'h00000011, 1);
    request(0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h00000044, 1);
    request(0, 1'b1, 1'b1, 32'h21, 32'hFFFFFF5A, 32'h11AA5A44, 1);
    request(0, 1'b1, 1'b0, 32'h1004, 32'hCAFEF00D, 32'hCAFEF00D, 1);
    request(0, 1'b0, 1'b0, 32'h6, 32'h0, 32'hCAFEF00D, 1);

    // valid and core yumi both held high: one accept every 4 cycles.
    @(posedge clk); #1;
    $display("txn dut0 held-valid load word addr=00000010 expect=deadbeef x3");
    repeat (3) exp_q0.push_back(32'hDEADBEEF);
    req[0].valid = 1'b1; req[0].wen = 1'b0; req[0].byte_not_word = 1'b0;
    req[0].yumi = 1'b1; addr[0] = 32'h10;
    yumis = 0;
    valids = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp[0].yumi) yumis++;
      if (rsp[0].valid) valids++;
      check("held_no_yumi_with_resp", 32'(rsp[0].yumi && rsp[0].valid), 32'd0);
      @(posedge clk);
    end
    #1 req[0].valid = 1'b0; req[0].yumi = 1'b0;
    check("held_yumi_count", 32'(yumis), 32'd3);
    check("held_valid_count", 32'(valids), 32'd3);

    // Reset while the store is in WAIT: response abandoned, write kept.
    @(posedge clk); #1;
    $display("txn dut0 store word addr=00000040 wdata=55667788 reset-in-wait");
    req[0].valid = 1'b1; req[0].wen = 1'b1; req[0].byte_not_word = 1'b0;
    req[0].write_data = 32'h55667788; addr[0] = 32'h40;
    @(negedge clk);
    check("rst_accept_yumi", 32'(rsp[0].yumi), 32'd1);
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_valid_low", 32'(rsp[0].valid), 32'd0);
    end
    request(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h55667788, 1);

    request(1, 1'b1, 1'b0, 32'h8, 32'h0BADC0DE, 32'h0BADC0DE, 1);
    request(1, 1'b0, 1'b1, 32'h9, 32'h0, 32'h000000C0, 1);
    request(1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0BADC0DE, 2);

    repeat (2) @(negedge clk);
    check("dut_queue_drained", 32'(exp_q0.size()), 32'd0);
    check("dut0_queue_drained", 32'(exp_q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
